// File: rtl/bram_arbiter.sv
// Round-robin arbiter for two requesters in front of one single-port BRAM.
// Ports: clk/reset, req{0,1}_* handshakes, resp{0,1}_*, bram_* RAM side,
// init_busy. Optional clear sweep: BRAM_ARB_INIT_CLEAR_EN.
module bram_arbiter #(
  parameter int DEPTH      = 65536,
  parameter int WIDTH      = 32,
  parameter int WRITE_BYTE = 0,
  parameter int WE_WIDTH   = WRITE_BYTE ? WIDTH / 8 : 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [AW-1:0]       req0_addr,
  input  logic [WIDTH-1:0]    req0_wdata,
  input  logic [WE_WIDTH-1:0] req0_we,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [AW-1:0]       req1_addr,
  input  logic [WIDTH-1:0]    req1_wdata,
  input  logic [WE_WIDTH-1:0] req1_we,
  output logic                resp0_valid,
  output logic [WIDTH-1:0]    resp0_rdata,
  output logic                resp1_valid,
  output logic [WIDTH-1:0]    resp1_rdata,
  output logic [AW-1:0]       bram_addr,
  output logic [WIDTH-1:0]    bram_din,
  output logic [WE_WIDTH-1:0] bram_we,
  input  logic [WIDTH-1:0]    bram_dout,
  output logic                init_busy
);

  logic ptr;
  logic run;
  logic g0;
  logic g1;

`ifdef BRAM_ARB_INIT_CLEAR_EN
  typedef enum logic {INIT, RUN} state_t;
  state_t        state;
  logic [AW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      cnt   <= '0;
    end else if (state == INIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == AW'(DEPTH - 1))
        state <= RUN;
    end
  end

  assign run = (state == RUN);
`else
  assign run = 1'b1;
`endif

  assign init_busy = ~run;

  // ptr = 1 gives requester 1 priority under contention
  assign g0 = req0_valid & (~req1_valid | ~ptr);
  assign g1 = req1_valid & (~req0_valid | ptr);

  assign req0_ready = g0 & run;
  assign req1_ready = g1 & run;

  always_comb begin
    bram_addr = '0;
    bram_din  = '0;
    bram_we   = '0;
    unique case (1'b1)
`ifdef BRAM_ARB_INIT_CLEAR_EN
      ~run: begin
        bram_addr = cnt;
        bram_we   = '1;
      end
`endif
      req0_ready: begin
        bram_addr = req0_addr;
        bram_din  = req0_wdata;
        bram_we   = req0_we;
      end
      req1_ready: begin
        bram_addr = req1_addr;
        bram_din  = req1_wdata;
        bram_we   = req1_we;
      end
      default: ;
    endcase
  end

  // Pointer always moves to the requester that was not served.
  // Response valids track reads one cycle behind the RAM address.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
    end else begin
      if (req0_ready)
        ptr <= 1'b1;
      else if (req1_ready)
        ptr <= 1'b0;
      resp0_valid <= req0_ready & ~|req0_we;
      resp1_valid <= req1_ready & ~|req1_we;
    end
  end

  assign resp0_rdata = bram_dout;
  assign resp1_rdata = bram_dout;

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter with a read-first byte-write RAM model.
// Expected reads are queued with their due cycle and popped by a monitor.
module tb_bram_arbiter;

  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);
  localparam int WEW   = 4;
`ifdef BRAM_ARB_INIT_CLEAR_EN
  localparam logic CLR = 1'b1;
`else
  localparam logic CLR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            req0_valid, req0_ready;
  logic [AW-1:0]   req0_addr;
  logic [31:0]     req0_wdata;
  logic [WEW-1:0]  req0_we;
  logic            req1_valid, req1_ready;
  logic [AW-1:0]   req1_addr;
  logic [31:0]     req1_wdata;
  logic [WEW-1:0]  req1_we;
  logic            resp0_valid, resp1_valid;
  logic [31:0]     resp0_rdata, resp1_rdata;
  logic [AW-1:0]   bram_addr;
  logic [31:0]     bram_din;
  logic [WEW-1:0]  bram_we;
  logic [31:0]     bram_dout;
  logic            init_busy;

  bram_arbiter #(.DEPTH(DEPTH), .WIDTH(32), .WRITE_BYTE(1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_we(req0_we),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_we(req1_we),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_we(bram_we),
    .bram_dout(bram_dout), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'hBAD0_0000 | i;

  always @(posedge clk) begin
    bram_dout <= mem[bram_addr];
    for (int b = 0; b < WEW; b++)
      if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (resp0_valid || resp1_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL resp_unexpected: got r0=%0b r1=%0b expected none (cycle %0d)",
                 resp0_valid, resp1_valid, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_id", {resp1_valid, resp0_valid}, e.id ? 2'b10 : 2'b01);
        chk("resp_cycle", cyc, e.due);
        chk("resp_data", resp0_valid ? resp0_rdata : resp1_rdata, e.data);
      end
    end
  end

  task automatic set0(input logic v, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [3:0] we);
    req0_valid = v; req0_addr = a; req0_wdata = d; req0_we = we;
  endtask

  task automatic set1(input logic v, input logic [AW-1:0] a,
                      input logic [31:0] d, input logic [3:0] we);
    req1_valid = v; req1_addr = a; req1_wdata = d; req1_we = we;
  endtask

  task automatic step(input logic e0, input logic e1,
                      input logic [31:0] x0, input logic [31:0] x1);
    @(negedge clk);
    chk("ready0", req0_ready, e0);
    chk("ready1", req1_ready, e1);
    if (e0 && req0_valid && req0_we == 4'h0) q.push_back('{1'b0, x0, cyc + 1});
    if (e1 && req1_valid && req1_we == 4'h0) q.push_back('{1'b1, x1, cyc + 1});
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input int start);
    int n;
    n = start;
    set0(1'b1, '0, '0, 4'h0);
    for (int i = 0; i < DEPTH + 4; i++) begin
      @(negedge clk);
      if (!init_busy) break;
      chk("init_ready0", req0_ready, 1'b0);
      n++;
    end
    req0_valid = 1'b0;
    chk("init_len", n, DEPTH);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set0(1'b0, '0, '0, 4'h0);
    set1(1'b0, '0, '0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_resp0", resp0_valid, 1'b0);
    chk("rst_resp1", resp1_valid, 1'b0);
    chk("rst_bram_we", bram_we, 4'h0);
    chk("rst_init_busy", init_busy, CLR);
    @(posedge clk);
    #1 reset = 1'b0;
`ifdef BRAM_ARB_INIT_CLEAR_EN
    wait_init(0);
`endif

    // single requester write then read-after-write
    set0(1'b1, 5'h10, 32'hDEADBEEF, 4'hF);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    set0(1'b1, 5'h10, 32'h0, 4'h0);
    step(1'b1, 1'b0, 32'hDEADBEEF, 32'h0);
    set0(1'b0, '0, '0, 4'h0);
    @(negedge clk);
    chk("idle_addr", bram_addr, 5'h0);
    chk("idle_din", bram_din, 32'h0);
    chk("idle_we", bram_we, 4'h0);
    @(posedge clk);
    #1;

    // preload for contention
    set1(1'b1, 5'h1, 32'hA1A1A1A1, 4'hF);
    step(1'b0, 1'b1, 32'h0, 32'h0);
    set1(1'b1, 5'h2, 32'hB2B2B2B2, 4'hF);
    step(1'b0, 1'b1, 32'h0, 32'h0);

    // contention: alternate 0,1,0,1
    set0(1'b1, 5'h1, 32'h0, 4'h0);
    set1(1'b1, 5'h2, 32'h0, 4'h0);
    step(1'b1, 1'b0, 32'hA1A1A1A1, 32'h0);
    step(1'b0, 1'b1, 32'h0, 32'hB2B2B2B2);
    step(1'b1, 1'b0, 32'hA1A1A1A1, 32'h0);
    step(1'b0, 1'b1, 32'h0, 32'hB2B2B2B2);
    set0(1'b0, '0, '0, 4'h0);

    // byte-lane write
    set1(1'b1, 5'h3, 32'h11223344, 4'hF);
    step(1'b0, 1'b1, 32'h0, 32'h0);
    set1(1'b1, 5'h3, 32'h0000AA00, 4'b0010);
    @(negedge clk);
    chk("partial_we_pass", bram_we, 4'b0010);
    @(posedge clk);
    #1;
    set1(1'b1, 5'h3, 32'h0, 4'h0);
    step(1'b0, 1'b1, 32'h0, 32'h1122AA44);

    // uncontended streaming on req1
    for (int i = 0; i < 8; i++) begin
      logic [AW-1:0] a;
      logic [31:0]   d;
      case (i % 4)
        0: begin a = 5'h1;  d = 32'hA1A1A1A1; end
        1: begin a = 5'h2;  d = 32'hB2B2B2B2; end
        2: begin a = 5'h3;  d = 32'h1122AA44; end
        default: begin a = 5'h10; d = 32'hDEADBEEF; end
      endcase
      set1(1'b1, a, 32'h0, 4'h0);
      step(1'b0, 1'b1, 32'h0, d);
    end
    set1(1'b0, '0, '0, 4'h0);

    // req0 write leaves pointer at req1
    set0(1'b1, 5'h4, 32'h00000055, 4'hF);
    step(1'b1, 1'b0, 32'h0, 32'h0);

    // reset with a read being accepted
    set0(1'b1, 5'h10, 32'h0, 4'h0);
    set1(1'b1, 5'h1, 32'h0, 4'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_cyc_ready0", req0_ready, 1'b0);
    chk("rst_cyc_ready1", req1_ready, 1'b1);
    @(posedge clk);
    #1 reset = 1'b0;
`ifdef BRAM_ARB_INIT_CLEAR_EN
    req1_valid = 1'b0;
    @(negedge clk);
    chk("flush_resp0", resp0_valid, 1'b0);
    chk("flush_resp1", resp1_valid, 1'b0);
    chk("flush_busy", init_busy, 1'b1);
    chk("flush_ready0", req0_ready, 1'b0);
    wait_init(1);
    set0(1'b1, 5'h10, 32'h0, 4'h0);
    set1(1'b1, 5'h1, 32'h0, 4'h0);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 32'h0, 32'h0);
    set1(1'b0, '0, '0, 4'h0);
    for (int a = 0; a < DEPTH; a++) begin
      set0(1'b1, AW'(a), 32'h0, 4'h0);
      step(1'b1, 1'b0, 32'h0, 32'h0);
    end
`else
    @(negedge clk);
    chk("flush_resp0", resp0_valid, 1'b0);
    chk("flush_resp1", resp1_valid, 1'b0);
    chk("ptr_rst_ready0", req0_ready, 1'b1);
    chk("ptr_rst_ready1", req1_ready, 1'b0);
    q.push_back('{1'b0, 32'hDEADBEEF, cyc + 1});
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 32'h0, 32'hA1A1A1A1);
`endif
    set0(1'b0, '0, '0, 4'h0);
    set1(1'b0, '0, '0, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
